product_accumulator: RTL and testbench

//  Downstream consumer of the 4x4 multiplier product (8-bit S1 path). Sums a

---
 rtl/product_accumulator_if.sv | 25 ++
 rtl/product_accumulator.sv | 86 ++++++++
 tb/tb_product_accumulator.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Product stream into the accumulator plus its run status/result outputs.
// Master drives start/prod; slave (the accumulator) returns acc/count/status.
interface product_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12
);
    logic              start;
    logic              prod_valid;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc;
    logic [7:0]        count;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output start, prod_valid, prod,
        input  acc, count, busy, done, overflow
    );

    modport slave (
        input  start, prod_valid, prod,
        output acc, count, busy, done, overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Saturating multiply-accumulate stage: sums NUM_TERMS valid products per run.
// Latency 1 cycle (acc registered); no backpressure, one product accepted per clock.
module product_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 12,
    parameter int NUM_TERMS = 4
) (
    input  logic clk,
    input  logic rst,
    product_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_TERMS - 1);

    state_t            state;
    logic [ACC_W-1:0]  accReg;
    logic [7:0]        countReg;
    logic              busyReg;
    logic              doneReg;
    logic              ovfReg;
    logic [ACC_W:0]    sumWide;

    // One extra bit catches the carry that triggers saturation.
    assign sumWide = {1'b0, accReg} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            accReg   <= '0;
            countReg <= '0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
            ovfReg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    doneReg <= 1'b0;
                    if (bus.start) begin
                        accReg   <= '0;
                        countReg <= '0;
                        ovfReg   <= 1'b0;
                        busyReg  <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.prod_valid) begin
                        if (sumWide[ACC_W]) begin
                            accReg <= '1;
                            ovfReg <= 1'b1;
                        end else begin
                            accReg <= sumWide[ACC_W-1:0];
                        end
                        countReg <= countReg + 8'd1;
                        if (countReg == LAST_IDX) begin
                            busyReg <= 1'b0;
                            doneReg <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Exactly one cycle; start is deliberately not re-sampled here.
                    doneReg <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busyReg <= 1'b0;
                    doneReg <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.acc      = accReg;
    assign bus.count    = countReg;
    assign bus.busy     = busyReg;
    assign bus.done     = doneReg;
    assign bus.overflow = ovfReg;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed plus randomized bench for product_accumulator across three parameter sets.
// Expected values come from a run-level arithmetic model (running sum clamped at max).
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [7:0] terms [4];

    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_W(8), .ACC_W(12)) b0 ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(9))  b9 ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(12)) b1 ();

    product_accumulator #(.PROD_W(8), .ACC_W(12), .NUM_TERMS(4))
        dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    product_accumulator #(.PROD_W(8), .ACC_W(9), .NUM_TERMS(4))
        dut9 (.clk(clk), .rst(rst), .bus(b9.slave));
    product_accumulator #(.PROD_W(8), .ACC_W(12), .NUM_TERMS(1))
        dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sat(input int unsigned s, input int unsigned mx);
        return (s > mx) ? mx : s;
    endfunction

    // One full run on the default instance using terms[]; optional stalls and a
    // stray start pulse while accumulating.
    task automatic run0(input int maxGap, input bit midStart);
        int unsigned sum;
        int gap;
        sum = 0;
        b0.start = 1'b1;
        tick;
        b0.start = 1'b0;
        chk("run.busy", 32'(b0.busy), 32'd1);
        chk("run.accClear", 32'(b0.acc), 32'd0);
        chk("run.countClear", 32'(b0.count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            gap = (maxGap == 0) ? 0 : int'($urandom_range(maxGap, 1));
            for (int g = 0; g < gap; g++) begin
                b0.prod_valid = 1'b0;
                b0.prod = 8'($urandom);
                tick;
                chk("stall.acc", 32'(b0.acc), sat(sum, 4095));
                chk("stall.count", 32'(b0.count), 32'(i));
            end
            b0.start = midStart && (i == 2);
            b0.prod_valid = 1'b1;
            b0.prod = terms[i];
            tick;
            b0.prod_valid = 1'b0;
            b0.start = 1'b0;
            sum += int'(terms[i]);
            chk("term.acc", 32'(b0.acc), sat(sum, 4095));
            chk("term.count", 32'(b0.count), 32'(i + 1));
            chk("term.busy", 32'(b0.busy), 32'(i < 3));
            chk("term.done", 32'(b0.done), 32'(i == 3));
        end
        tick;
        chk("post.done", 32'(b0.done), 32'd0);
        chk("post.busy", 32'(b0.busy), 32'd0);
        chk("post.acc", 32'(b0.acc), sat(sum, 4095));
        chk("post.ovf", 32'(b0.overflow), 32'd0);
    endtask

    initial begin
        int unsigned sum;
        logic [7:0] p;
        logic [11:0] heldAcc;

        rst = 1'b1;
        b0.start = 1'b0; b0.prod_valid = 1'b0; b0.prod = '0;
        b9.start = 1'b0; b9.prod_valid = 1'b0; b9.prod = '0;
        b1.start = 1'b0; b1.prod_valid = 1'b0; b1.prod = '0;
        tick;
        tick;
        chk("rst.acc", 32'(b0.acc), 32'd0);
        chk("rst.count", 32'(b0.count), 32'd0);
        chk("rst.busy", 32'(b0.busy), 32'd0);
        chk("rst.done", 32'(b0.done), 32'd0);
        chk("rst.ovf", 32'(b0.overflow), 32'd0);
        chk("rst.acc9", 32'(b9.acc), 32'd0);
        chk("rst.acc1", 32'(b1.acc), 32'd0);
        rst = 1'b0;
        tick;

        // Back-to-back terms
        terms[0] = 8'd10; terms[1] = 8'd20; terms[2] = 8'd30; terms[3] = 8'd40;
        run0(0, 1'b0);
        // Stalls of 1-3 cycles between terms
        run0(3, 1'b0);
        // Stray start while accumulating
        run0(0, 1'b1);

        // Valid products in IDLE must not disturb the held result
        heldAcc = b0.acc;
        for (int i = 0; i < 3; i++) begin
            b0.prod_valid = 1'b1;
            b0.prod = 8'($urandom);
            tick;
            chk("idle.acc", 32'(b0.acc), 32'(heldAcc));
            chk("idle.count", 32'd4, 32'(b0.count));
            chk("idle.busy", 32'(b0.busy), 32'd0);
        end
        b0.prod_valid = 1'b0;

        // Asynchronous reset between edges after two terms
        b0.start = 1'b1;
        tick;
        b0.start = 1'b0;
        b0.prod_valid = 1'b1;
        b0.prod = 8'd10;
        tick;
        b0.prod = 8'd20;
        tick;
        b0.prod_valid = 1'b0;
        chk("arst.pre", 32'(b0.acc), 32'd30);
        #2 rst = 1'b1;
        #1;
        chk("arst.acc", 32'(b0.acc), 32'd0);
        chk("arst.count", 32'(b0.count), 32'd0);
        chk("arst.busy", 32'(b0.busy), 32'd0);
        chk("arst.ovf", 32'(b0.overflow), 32'd0);
        tick;
        rst = 1'b0;
        tick;
        chk("arst.noDone", 32'(b0.done), 32'd0);
        terms[0] = 8'd5; terms[1] = 8'd5; terms[2] = 8'd5; terms[3] = 8'd5;
        run0(0, 1'b0);

        // Random runs on the default instance
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 4; i++) terms[i] = 8'($urandom);
            run0((r % 2) * 3, 1'b0);
        end

        // 9-bit accumulator: first run saturates, later runs random
        for (int r = 0; r < 8; r++) begin
            sum = 0;
            b9.start = 1'b1;
            tick;
            b9.start = 1'b0;
            chk("a9.accClear", 32'(b9.acc), 32'd0);
            chk("a9.ovfClear", 32'(b9.overflow), 32'd0);
            for (int i = 0; i < 4; i++) begin
                p = (r == 0) ? 8'd225 : 8'($urandom);
                b9.prod_valid = 1'b1;
                b9.prod = p;
                tick;
                sum += int'(p);
                chk("a9.acc", 32'(b9.acc), sat(sum, 511));
                chk("a9.ovf", 32'(b9.overflow), 32'(sum > 511));
            end
            b9.prod_valid = 1'b0;
            chk("a9.done", 32'(b9.done), 32'd1);
            tick;
        end

        // Single-term instance
        b1.start = 1'b1;
        tick;
        b1.start = 1'b0;
        chk("n1.busy", 32'(b1.busy), 32'd1);
        b1.prod_valid = 1'b1;
        b1.prod = 8'd255;
        tick;
        b1.prod_valid = 1'b0;
        chk("n1.acc", 32'(b1.acc), 32'd255);
        chk("n1.count", 32'(b1.count), 32'd1);
        chk("n1.done", 32'(b1.done), 32'd1);
        chk("n1.busyLow", 32'(b1.busy), 32'd0);
        tick;
        chk("n1.doneLow", 32'(b1.done), 32'd0);
        chk("n1.hold", 32'(b1.acc), 32'd255);

        // start held high: re-arms only after returning to IDLE
        b1.start = 1'b1;
        tick;
        chk("held.busy", 32'(b1.busy), 32'd1);
        chk("held.acc", 32'(b1.acc), 32'd0);
        b1.prod_valid = 1'b1;
        b1.prod = 8'd7;
        tick;
        b1.prod_valid = 1'b0;
        chk("held.done", 32'(b1.done), 32'd1);
        chk("held.acc7", 32'(b1.acc), 32'd7);
        tick;
        chk("held.idleBusy", 32'(b1.busy), 32'd0);
        chk("held.idleDone", 32'(b1.done), 32'd0);
        chk("held.idleAcc", 32'(b1.acc), 32'd7);
        tick;
        chk("held.rearm", 32'(b1.busy), 32'd1);
        chk("held.rearmAcc", 32'(b1.acc), 32'd0);
        b1.start = 1'b0;
        b1.prod_valid = 1'b1;
        b1.prod = 8'd9;
        tick;
        b1.prod_valid = 1'b0;
        chk("held.done2", 32'(b1.done), 32'd1);
        chk("held.acc9", 32'(b1.acc), 32'd9);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
